// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and the LFSR shift function for the
// random-draw arbiter and its LFSR core.
package lfsr_pkg;

   localparam int                 LFSR_W     = 8;
   localparam logic [LFSR_W-1:0]  LFSR_RESET = 8'h01;
   // Feedback taps: bits 4, 3, 2 and 0
   localparam logic [LFSR_W-1:0]  LFSR_TAPS  = 8'b0001_1101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      DELIVER = 2'd2
   } state_t;

   // One right shift; the tap parity enters at the MSB
   function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] v);
      return {^(v & LFSR_TAPS), v[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit LFSR register with seed load and zero lock-up guard.
// A load takes priority over a step in the same cycle.
module lfsr8_core
   import lfsr_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_load_val,
   input  logic              i_step,
   output logic [LFSR_W-1:0] o_q
);

   logic [LFSR_W-1:0] r_q;

   // LFSR register: reset, guarded seed load, or one shift
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= LFSR_RESET;
      end else if (i_load) begin
         // all-zero is a lock-up state for this LFSR
         r_q <= (i_load_val == '0) ? LFSR_RESET : i_load_val;
      end else if (i_step) begin
         r_q <= lfsr_shift(r_q);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter sharing one 8-bit LFSR between NUM_REQ requesters.
// Each grant advances the LFSR STEPS times and delivers the byte with the
// requester id. Optional build macro LFSR_FREERUN_EN: when defined the LFSR
// also shifts on every IDLE cycle without a seed load.
//
// state   | meaning
// IDLE    | wait for seed_load or a request; seed load has priority
// STEP    | shift LFSR once per cycle, STEPS cycles, winner latched
// DELIVER | one-cycle gnt/rnd_valid pulse, advance round-robin pointer
module lfsr_draw_arbiter
   import lfsr_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int STEPS   = 1,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_seed_load,
   input  logic [7:0]         i_seed,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_rnd_valid,
   output logic [7:0]         o_rnd_data,
   output logic [ID_W-1:0]    o_rnd_id,
   output logic               o_busy
);

   localparam logic [1:0]         S_IDLE    = IDLE;
   localparam logic [1:0]         S_STEP    = STEP;
   localparam logic [1:0]         S_DELIVER = DELIVER;
   localparam logic [3:0]         STEP_LAST = 4'(STEPS - 1);
   localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
   localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

   logic [1:0]           r_state;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [ID_W-1:0]      r_winner;
   logic [3:0]           r_step_cnt;
   logic [NUM_REQ-1:0]   r_gnt;
   logic                 r_rnd_valid;
   logic [7:0]           r_rnd_data;
   logic [ID_W-1:0]      r_rnd_id;
   logic                 r_busy;

   logic [LFSR_W-1:0]    w_lfsr;
   logic                 w_lfsr_load;
   logic                 w_lfsr_step;
   logic [2*NUM_REQ-1:0] w_req_rot_full;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic                 w_win_found;
   logic [ID_W-1:0]      w_win_off;
   logic [ID_W:0]        w_win_sum;
   logic [ID_W-1:0]      w_win_idx;

   assign w_lfsr_load = (r_state == S_IDLE) && i_seed_load;
`ifdef LFSR_FREERUN_EN
   assign w_lfsr_step = (r_state == S_STEP) || ((r_state == S_IDLE) && !i_seed_load);
`else
   assign w_lfsr_step = (r_state == S_STEP);
`endif

   lfsr8_core u_lfsr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_lfsr_load),
      .i_load_val (i_seed),
      .i_step     (w_lfsr_step),
      .o_q        (w_lfsr)
   );

   // Rotate requests so that bit 0 corresponds to the round-robin pointer
   assign w_req_rot_full = {i_req, i_req} >> r_rr_ptr;
   assign w_req_rot      = w_req_rot_full[NUM_REQ-1:0];

   // First asserted request at or after the pointer, with wrap
   always_comb begin
      w_win_found = 1'b0;
      w_win_off   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_win_found && w_req_rot[i]) begin
            w_win_found = 1'b1;
            w_win_off   = ID_W'(i);
         end
      end
      w_win_sum = {1'b0, r_rr_ptr} + {1'b0, w_win_off};
      w_win_idx = (w_win_sum >= NUM_REQ_W) ? ID_W'(w_win_sum - NUM_REQ_W)
                                           : ID_W'(w_win_sum);
   end

   // FSM, round-robin pointer and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_winner    <= '0;
         r_step_cnt  <= '0;
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         r_rnd_data  <= 8'h00;
         r_rnd_id    <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // a seed load in the same cycle defers arbitration
               if (!i_seed_load && w_win_found) begin
                  r_winner   <= w_win_idx;
                  r_step_cnt <= '0;
                  r_state    <= S_STEP;
                  r_busy     <= 1'b1;
               end
            end
            S_STEP: begin
               r_step_cnt <= r_step_cnt + 4'd1;
               if (r_step_cnt == STEP_LAST) begin
                  // outputs are loaded here so they are valid during DELIVER;
                  // the LFSR performs its last shift on this same edge
                  r_state     <= S_DELIVER;
                  r_gnt       <= GNT_ONE << r_winner;
                  r_rnd_valid <= 1'b1;
                  r_rnd_data  <= lfsr_shift(w_lfsr);
                  r_rnd_id    <= r_winner;
               end
            end
            S_DELIVER: begin
               r_rr_ptr <= (r_winner == ID_LAST) ? '0 : r_winner + 1'b1;
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_rnd_valid = r_rnd_valid;
   assign o_rnd_data  = r_rnd_data;
   assign o_rnd_id    = r_rnd_id;
   assign o_busy      = r_busy;

endmodule
